// File: rtl/crcu_rst_pkg.sv
// rtl/crcu_rst_pkg.sv - shared types and control word layout for the reset generator
package crcu_rst_pkg;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEVEL = 2'd1,
        HOLD  = 2'd2
    } ch_state_e;

    // Control word width and field offsets
    localparam int CTL_W    = 32;
    localparam int TRIG_BIT = 0;
    localparam int EN_BIT   = 1;
    localparam int MODE_BIT = 2;
    localparam int DUR_LSB  = 3;

endpackage

// File: rtl/rst_gen_ch.sv
// rtl/rst_gen_ch.sv - single reset channel: FSM, hold counter, trigger edge detect, done pulse
module rst_gen_ch
    import crcu_rst_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CRCU_CLK,
    input  logic             CRCU_RST,
    input  logic [CTL_W-1:0] i_ctl,
    input  logic             start_in,
    output logic             o_rst,
    output logic             o_busy,
    output logic             o_done
);

    ch_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_d;
    logic             r_trig_q;
    logic             r_pend;
    logic             r_pwron;
    logic             r_rst;
    logic             r_busy;
    logic             r_done;

    logic             w_trig;
    logic             w_en;
    logic             w_mode;
    logic             w_trig_edge;
    logic [CNT_W-1:0] w_dur;
    logic [CNT_W-1:0] w_dur_eff;
    logic [CNT_W-1:0] w_term_d;
    logic             w_term;
    logic             w_unused_ctl;

    assign w_trig       = i_ctl[TRIG_BIT];
    assign w_en         = i_ctl[EN_BIT];
    assign w_mode       = i_ctl[MODE_BIT];
    assign w_dur        = i_ctl[DUR_LSB +: CNT_W];
    assign w_unused_ctl = ^i_ctl[CTL_W-1:DUR_LSB+CNT_W];

    // A zero duration still produces a one-cycle reset
    assign w_dur_eff   = (w_dur == '0) ? CNT_W'(1) : w_dur;
    assign w_trig_edge = w_trig & ~r_trig_q;

    // The cycle that consumes the power-on start is count 0, so its length
    // comes straight from the register rather than the not-yet-latched copy
    assign w_term_d = r_pend ? w_dur_eff : r_d;
    assign w_term   = (r_cnt == (w_term_d - CNT_W'(1)));

    // Channel FSM with counter, trigger history and registered outputs
    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            r_state  <= HOLD;
            r_cnt    <= '0;
            r_d      <= '0;
            r_trig_q <= 1'b0;
            r_pend   <= 1'b1;
            r_pwron  <= 1'b1;
            r_rst    <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_trig_q <= w_trig;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trig_edge && w_en) begin
                        r_rst  <= 1'b1;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (w_mode) begin
                            r_state <= LEVEL;
                        end else begin
                            r_state <= HOLD;
                            r_d     <= w_dur_eff;
                        end
                    end
                end
                LEVEL: begin
                    // r_trig_q low means sw_trig was sampled low one edge ago
                    if (!r_trig_q) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                        r_d     <= w_dur_eff;
                    end
                end
                HOLD: begin
                    if (r_pend && !start_in) begin
                        r_cnt <= '0;
                    end else if (w_trig_edge && !r_pwron) begin
                        r_cnt <= '0;
                        if (w_mode) begin
                            r_state <= LEVEL;
                        end else begin
                            r_d <= w_dur_eff;
                        end
                    end else if (w_term) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_rst   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pend  <= 1'b0;
                        r_pwron <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_pend) begin
                            r_d    <= w_dur_eff;
                            r_pend <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_rst   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst  = r_rst;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/multi_ch_rst_gen.sv
// rtl/multi_ch_rst_gen.sv - multi-channel reset generator with optional sequenced power-on release
module multi_ch_rst_gen
    import crcu_rst_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int SEQ_PWRON = 1
) (
    input  logic                    CRCU_CLK,
    input  logic                    CRCU_RST,
    input  logic [NUM_CH*CTL_W-1:0] rst_ctl_reg,
    output logic [NUM_CH-1:0]       rst,
    output logic [NUM_CH-1:0]       rst_busy,
    output logic [NUM_CH-1:0]       rst_done
);

    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_done;

    assign rst_done = w_done;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Sequenced release hands the start token down the channel chain
        if (SEQ_PWRON != 0 && k > 0) begin : g_seq
            assign w_start[k] = w_done[k-1];
        end else begin : g_par
            assign w_start[k] = 1'b1;
        end

        rst_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .CRCU_CLK (CRCU_CLK),
            .CRCU_RST (CRCU_RST),
            .i_ctl    (rst_ctl_reg[k*CTL_W +: CTL_W]),
            .start_in (w_start[k]),
            .o_rst    (rst[k]),
            .o_busy   (rst_busy[k]),
            .o_done   (w_done[k])
        );
    end

endmodule

// File: tb/tb_multi_ch_rst_gen.sv
// tb/tb_multi_ch_rst_gen.sv - scoreboard bench for multi_ch_rst_gen
module tb_multi_ch_rst_gen;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic               clk = 1'b0;
    logic               rst_in = 1'b1;
    logic [NCH*32-1:0]  ctl = '0;
    logic [NCH-1:0]     rst_o;
    logic [NCH-1:0]     busy_o;
    logic [NCH-1:0]     done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_q[NCH][$];
    int rise_cyc[NCH];
    logic [NCH-1:0] prev_rst = '0;

    multi_ch_rst_gen #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .SEQ_PWRON (1)
    ) dut (
        .CRCU_CLK    (clk),
        .CRCU_RST    (rst_in),
        .rst_ctl_reg (ctl),
        .rst         (rst_o),
        .rst_busy    (busy_o),
        .rst_done    (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < NCH; k++) n += exp_q[k].size();
        return n;
    endfunction

    // Monitor: measure each rst pulse and score it when rst_done appears
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rst_in) begin
                rise_cyc[k] = cyc + 1;
            end else begin
                if (rst_o[k] && !prev_rst[k]) rise_cyc[k] = cyc;
                if (done_o[k]) begin
                    check($sformatf("done_with_rst_low ch%0d", k), {31'd0, rst_o[k]}, 32'd0);
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done ch%0d: got done at cycle %0d expected none", k, cyc);
                    end else begin
                        int e;
                        e = exp_q[k].pop_front();
                        check($sformatf("pulse_len ch%0d", k), cyc - rise_cyc[k], e);
                    end
                end
            end
        end
        prev_rst = rst_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic trig, input logic en, input logic mode, input int dur);
        logic [31:0] w;
        w = '0;
        w[0] = trig;
        w[1] = en;
        w[2] = mode;
        w[3 +: CW] = dur[CW-1:0];
        ctl[k*32 +: 32] = w;
    endtask

    task automatic set_trig(input int k, input logic v);
        ctl[k*32] = v;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (n < max_cyc && pending() != 0) begin
            tick(1);
            n++;
        end
        check("drain_outstanding", pending(), 0);
        tick(3);
    endtask

    task automatic power_on_setup();
        set_ch(0, 0, 0, 0, 3);
        set_ch(1, 0, 0, 0, 5);
        set_ch(2, 0, 0, 0, 1);
        set_ch(3, 0, 0, 0, 0);
    endtask

    task automatic push_power_on();
        exp_q[0].push_back(3);
        exp_q[1].push_back(8);
        exp_q[2].push_back(9);
        exp_q[3].push_back(10);
    endtask

    initial begin
        rst_in = 1'b1;
        power_on_setup();
        tick(3);
        check("reset_rst", rst_o, 32'hF);
        check("reset_busy", busy_o, 32'hF);
        check("reset_done", done_o, 32'h0);

        // Sequenced power-on; a trigger on ch3 while still pending is ignored
        push_power_on();
        rst_in = 1'b0;
        tick(1);
        set_ch(3, 1, 1, 0, 0);
        tick(1);
        set_trig(3, 0);
        drain(60);
        set_ch(3, 0, 0, 0, 0);

        // Pulse mode, 10 cycles
        set_ch(1, 0, 1, 0, 10);
        tick(1);
        exp_q[1].push_back(10);
        set_trig(1, 1);
        tick(1);
        set_trig(1, 0);
        drain(40);

        // Retrigger after 6 HOLD cycles: 6 + 10
        exp_q[1].push_back(16);
        set_trig(1, 1);
        tick(1);
        set_trig(1, 0);
        tick(5);
        set_trig(1, 1);
        tick(1);
        set_trig(1, 0);
        drain(60);

        // Level-extend: 20 cycles high, 1 transition cycle, 4 HOLD cycles
        set_ch(2, 0, 1, 1, 4);
        tick(1);
        exp_q[2].push_back(25);
        set_trig(2, 1);
        tick(20);
        set_trig(2, 0);
        drain(60);

        // Disabled channel ignores toggling triggers
        set_ch(0, 0, 0, 0, 8);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            set_trig(0, (i % 2) == 0);
            tick(1);
            if (i % 3 == 0) check($sformatf("disabled_ch0_low step%0d", i), {31'd0, rst_o[0]}, 32'd0);
        end
        set_trig(0, 0);
        tick(2);
        check("disabled_ch0_low end", {31'd0, rst_o[0]}, 32'd0);

        // Duration and enable changes mid-HOLD do not alter the latched count
        set_ch(0, 0, 1, 0, 8);
        tick(1);
        exp_q[0].push_back(8);
        set_trig(0, 1);
        tick(1);
        set_trig(0, 0);
        tick(2);
        set_ch(0, 0, 0, 0, 2);
        drain(40);

        // Asynchronous master reset mid-count, then power-on repeats
        set_ch(1, 0, 1, 0, 10);
        tick(1);
        exp_q[1].push_back(10);
        set_trig(1, 1);
        tick(1);
        set_trig(1, 0);
        tick(5);
        #2;
        rst_in = 1'b1;
        for (int k = 0; k < NCH; k++) exp_q[k].delete();
        #1;
        check("async_reset_rst", rst_o, 32'hF);
        check("async_reset_busy", busy_o, 32'hF);
        check("async_reset_done", done_o, 32'h0);
        power_on_setup();
        tick(3);
        push_power_on();
        rst_in = 1'b0;
        drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_ch_rst_gen.md
MULTI_CH_RST_GEN -- requirements
Module: multi_ch_rst_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent reset channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: duration counter width, range 1..16.
REQ-003 Parameter SEQ_PWRON, default 1: 1 = power-on releases are sequenced in channel index order; 0 = all channels release in parallel.
REQ-004 CRCU_CLK  input  1  sole clock; all state is updated on its rising edge.
REQ-005 CRCU_RST  input  1  master reset; asynchronous and active-high.
REQ-006 rst_ctl_reg  input  NUM_CH*32  per-channel control words set by APB; channel k occupies bits [32k+31:32k].
REQ-007 Control word fields: bit0 sw_trig; bit1 ch_en; bit2 mode (0 = pulse, 1 = level-extend); bits[3+CNT_W-1:3] duration; all other bits are ignored.
REQ-008 rst  output  NUM_CH  active-high reset, one bit per channel.
REQ-009 rst_busy  output  NUM_CH  1 while the channel is in HOLD or LEVEL.
REQ-010 rst_done  output  NUM_CH  1-cycle pulse in the cycle rst[k] falls.

Function
REQ-011 Each channel runs its own FSM with states IDLE (rst=0), LEVEL (rst=1) and HOLD (rst=1, counter running).
REQ-012 A trigger is a sw_trig 0->1 edge, detected against a registered copy of sw_trig that resets to 0.
REQ-013 IDLE -> HOLD on a trigger when ch_en=1 and mode=0; IDLE -> LEVEL on a trigger when ch_en=1 and mode=1.
REQ-014 While ch_en=0, triggers in IDLE are ignored and the channel remains in IDLE.
REQ-015 LEVEL -> HOLD in the cycle after sw_trig is sampled low; rst stays high across the transition.
REQ-016 On every entry to HOLD: counter is set to 0 and D = max(duration,1) is latched; later register writes have no effect until the next entry.
REQ-017 In HOLD the counter increments by 1 each cycle; HOLD -> IDLE when counter == D-1.
REQ-018 rst is high for exactly D cycles in HOLD, plus every cycle spent in LEVEL.
REQ-019 A trigger in HOLD with mode=0 restarts the count: counter reloads to 0 and D is re-latched; rst stays high.
REQ-020 A trigger in HOLD with mode=1 moves the channel to LEVEL.
REQ-021 Clearing ch_en in HOLD or LEVEL does not abort the sequence; the channel completes normally.
REQ-022 rst_done[k] is high for 1 cycle on every HOLD -> IDLE transition and at no other time.
REQ-023 The counter is CNT_W bits wide and never wraps: the terminal compare at D-1 always fires first.
REQ-024 Channels are fully independent except for the power-on ordering in REQ-026.

Reset
REQ-025 While CRCU_RST=1: rst = all ones, rst_busy = all ones, rst_done = 0, counters = 0, sw_trig edge registers = 0, all FSMs in HOLD with a pending start.
REQ-026 After CRCU_RST deasserts, channel 0 starts its HOLD count on the first clock edge, with D latched from its duration.
REQ-027 With SEQ_PWRON=1, channel k>0 starts counting on the cycle after rst_done[k-1]; until then rst[k]=1 and counter[k]=0.
REQ-028 With SEQ_PWRON=0, all channels start counting on the first edge after CRCU_RST deasserts.
REQ-029 Power-on release ignores ch_en and mode.
REQ-030 Triggers received before a channel's power-on release completes are ignored.
REQ-031 An assertion of CRCU_RST at any time, including mid-count, immediately returns every channel to the state of REQ-025.

Structure
REQ-032 Package crcu_rst_pkg holds the FSM state enum (IDLE, LEVEL, HOLD), the field offsets (TRIG_BIT=0, EN_BIT=1, MODE_BIT=2, DUR_LSB=3) and the control word width constant 32.
REQ-033 Sub-module rst_gen_ch implements one channel: FSM, counter, edge detect and done pulse, with a start_in input used for power-on sequencing.
REQ-034 The top level instantiates NUM_CH copies of rst_gen_ch in a generate loop and chains done outputs to start inputs when SEQ_PWRON=1.

Verification
REQ-035 NUM_CH=4, SEQ_PWRON=1, durations 3/5/1/0, release CRCU_RST -> rst[0..3] fall 3, 8, 9 and 10 cycles after release, each with a 1-cycle rst_done.
REQ-036 Ch1 mode=0, duration=10, ch_en=1; pulse sw_trig -> rst[1] is high for exactly 10 cycles starting the cycle after the edge is detected.
REQ-037 Ch1 duration=10 with a retrigger at count 6 -> rst[1] is high for 6+10=16 cycles in total, with one rst_done.
REQ-038 Ch2 mode=1, duration=4; hold sw_trig high for 20 cycles -> rst[2] is high for the 20 cycles plus 1 transition cycle plus 4 cycles.
REQ-039 Ch0 ch_en=0 with sw_trig toggling -> rst[0] stays 0; change duration from 8 to 2 mid-HOLD -> the 8-cycle count completes unchanged.
REQ-040 Assert CRCU_RST at count 5 of a 10-cycle HOLD -> all rst bits go high asynchronously, and the power-on sequence restarts after release.
